// File: rtl/ctrl_pkg.sv
// Multicycle RV32I control: shared state, opcode and control encodings.
// Imported by ctrl_next_state and multicycle_ctrl_fsm.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_EX_LDSD = 4'd4,
    S_EX_B    = 4'd5,
    S_EX_JAL  = 4'd6,
    S_EX_JALR = 4'd7,
    S_WB_R    = 4'd8,
    S_MEM_LD  = 4'd9,
    S_MEM_SD  = 4'd10,
    S_MEM_B   = 4'd11,
    S_WB_LD   = 4'd12,
    S_EC      = 4'd13,
    S_HALT    = 4'd14,
    S_TRAP    = 4'd15
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
  } ctrl_t;

  function automatic state_e decode(
    input logic [6:0] op
  );
    state_e s;
    unique case (op)
      OP_R:      s = S_EX_R;
      OP_I:      s = S_EX_I;
      OP_LOAD:   s = S_EX_LDSD;
      OP_STORE:  s = S_EX_LDSD;
      OP_BRANCH: s = S_EX_B;
      OP_JAL:    s = S_EX_JAL;
      OP_JALR:   s = S_EX_JALR;
      OP_SYSTEM: s = S_EC;
      default:   s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_next_state.sv
// Combinational next-state function of the multicycle control FSM.
// In: i_state, i_opcode, i_bcond, i_mem_ready, i_halt_req, i_timeout. Out: o_next.
module ctrl_next_state
  import ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [6:0] i_opcode,
  input  logic       i_bcond,
  input  logic       i_mem_ready,
  input  logic       i_halt_req,
  input  logic       i_timeout,
  output state_e     o_next
);

  always_comb begin
    o_next = i_state;
    if (i_timeout) begin
      o_next = S_TRAP;
    end else begin
      unique case (i_state)
        S_IF: begin
          if (i_mem_ready) o_next = S_ID;
        end
        S_ID: o_next = decode(i_opcode);
        S_EX_R,
        S_EX_I: o_next = S_WB_R;
        S_EX_LDSD: begin
          if (i_opcode == OP_LOAD) o_next = S_MEM_LD;
          else                     o_next = S_MEM_SD;
        end
        S_EX_B: begin
          if (i_bcond) o_next = S_MEM_B;
          else         o_next = S_IF;
        end
        S_MEM_LD: begin
          if (i_mem_ready) o_next = S_WB_LD;
        end
        S_MEM_SD: begin
          if (i_mem_ready) o_next = S_IF;
        end
        S_WB_R,
        S_WB_LD,
        S_MEM_B,
        S_EX_JAL,
        S_EX_JALR: o_next = S_IF;
        S_EC: begin
          if (i_halt_req) o_next = S_HALT;
          else            o_next = S_IF;
        end
        S_HALT,
        S_TRAP: o_next = i_state;
        default: o_next = S_TRAP;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM: IF/ID/EX/MEM/WB sequencing, memory wait
// timeout, illegal-opcode trap, ECALL halt.
// Ports: clk, reset (async active-low), opcode, alu_bcond, mem_ready,
// halt_req in; datapath enables/selects, sticky flags and counters out.
// Optional feature macro: CTRL_PERF_CNT_EN (cycle_cnt / instret_cnt).
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int WAIT_W  = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               alu_bcond,
  input  logic               mem_ready,
  input  logic               halt_req,
  output logic               pc_write,
  output logic               i_or_d,
  output logic               mem_req,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               reg_write,
  output logic               illegal_inst,
  output logic               halted,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  state_e            r_state;
  state_e            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_illegal;
  logic              r_halted;
  logic              r_timeout;
  ctrl_t             w_ctl;
  ctrl_t             w_out;
  logic              w_stall;
  logic              w_timeout;

  assign w_stall   = w_ctl.mem_req && !mem_ready;
  assign w_timeout = w_stall && (r_wait == WAIT_MAX);

  ctrl_next_state u_ns (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_bcond     (alu_bcond),
    .i_mem_ready (mem_ready),
    .i_halt_req  (halt_req),
    .i_timeout   (w_timeout),
    .o_next      (w_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait counter only advances while a request is stalled in one state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait <= '0;
    end else if ((w_next != r_state) || !w_stall) begin
      r_wait <= '0;
    end else if (r_wait != WAIT_MAX) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_illegal <= 1'b0;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == S_ID) && (w_next == S_TRAP))
        r_illegal <= 1'b1;
      if (w_next == S_HALT)
        r_halted <= 1'b1;
      if (w_timeout)
        r_timeout <= 1'b1;
    end
  end

  // PC+4 for WB/store retire is recomputed by the ALU from PC, since
  // ALUOut has been overwritten by the execute result by then.
  always_comb begin
    w_ctl = '0;
    unique case (r_state)
      S_IF: begin
        w_ctl.mem_req  = 1'b1;
        w_ctl.mem_read = 1'b1;
        w_ctl.ir_write = mem_ready;
      end
      S_ID: begin
        w_ctl.alu_op    = ALU_ADD;
        w_ctl.alu_src_b = SRCB_4;
      end
      S_EX_R: begin
        w_ctl.alu_op    = ALU_FN;
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_RS2;
      end
      S_EX_I: begin
        w_ctl.alu_op    = ALU_FN;
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
      end
      S_WB_R: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.pc_write  = 1'b1;
        w_ctl.alu_src_b = SRCB_4;
      end
      S_EX_LDSD: begin
        w_ctl.alu_op    = ALU_ADD;
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
      end
      S_MEM_LD: begin
        w_ctl.mem_req  = 1'b1;
        w_ctl.mem_read = 1'b1;
        w_ctl.i_or_d   = 1'b1;
      end
      S_WB_LD: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = 1'b1;
        w_ctl.pc_write   = 1'b1;
        w_ctl.alu_src_b  = SRCB_4;
      end
      S_MEM_SD: begin
        w_ctl.mem_req   = 1'b1;
        w_ctl.mem_write = 1'b1;
        w_ctl.i_or_d    = 1'b1;
        w_ctl.pc_write  = mem_ready;
        w_ctl.alu_src_b = SRCB_4;
      end
      S_EX_B: begin
        w_ctl.alu_op    = ALU_BR;
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_RS2;
        w_ctl.pc_write  = !alu_bcond;
        w_ctl.pc_source = !alu_bcond;
      end
      S_MEM_B: begin
        w_ctl.pc_write  = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
      end
      S_EX_JAL: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.pc_write  = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
      end
      S_EX_JALR: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.pc_write  = 1'b1;
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
      end
      S_EC: begin
        w_ctl.pc_write  = !halt_req;
        w_ctl.pc_source = !halt_req;
      end
      default: w_ctl = '0;
    endcase
  end

  // Gate with reset so a pending request drops without a clock edge.
  assign w_out = reset ? w_ctl : '0;

  assign pc_write     = w_out.pc_write;
  assign i_or_d       = w_out.i_or_d;
  assign mem_req      = w_out.mem_req;
  assign mem_read     = w_out.mem_read;
  assign mem_write    = w_out.mem_write;
  assign ir_write     = w_out.ir_write;
  assign mem_to_reg   = w_out.mem_to_reg;
  assign pc_source    = w_out.pc_source;
  assign alu_op       = ALUOP_W'(w_out.alu_op);
  assign alu_src_a    = w_out.alu_src_a;
  assign alu_src_b    = w_out.alu_src_b;
  assign reg_write    = w_out.reg_write;
  assign illegal_inst = r_illegal;
  assign halted       = r_halted;
  assign mem_timeout  = r_timeout;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;
  logic             w_run;
  logic             w_retire;

  assign w_run    = (r_state != S_HALT) && (r_state != S_TRAP);
  assign w_retire = (w_next == S_IF) && (r_state != S_IF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      if (w_run)    r_cycle   <= r_cycle + 1'b1;
      if (w_retire) r_instret <= r_instret + 1'b1;
    end
  end

  assign cycle_cnt   = r_cycle;
  assign instret_cnt = r_instret;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-cycle control vectors,
// sticky flags, counters, timeout and async reset abort.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        alu_bcond;
  logic        mem_ready;
  logic        halt_req;
  logic        pc_write;
  logic        i_or_d;
  logic        mem_req;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        mem_to_reg;
  logic        pc_source;
  logic [1:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        reg_write;
  logic        illegal_inst;
  logic        halted;
  logic        mem_timeout;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  multicycle_ctrl_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .alu_bcond    (alu_bcond),
    .mem_ready    (mem_ready),
    .halt_req     (halt_req),
    .pc_write     (pc_write),
    .i_or_d       (i_or_d),
    .mem_req      (mem_req),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .mem_to_reg   (mem_to_reg),
    .pc_source    (pc_source),
    .alu_op       (alu_op),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .reg_write    (reg_write),
    .illegal_inst (illegal_inst),
    .halted       (halted),
    .mem_timeout  (mem_timeout),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;
  int m_cyc;
  int m_ret;
  logic [13:0] sb[$];

  task automatic chk(input string t, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask

  function automatic logic [13:0] cv(
    input bit pcw, iod, req, rd, wr, irw, m2r, pcs,
    input bit [1:0] aop, input bit sa, input bit [1:0] sb_,
    input bit rw);
    return {pcw, iod, req, rd, wr, irw, m2r, pcs, aop, sa, sb_, rw};
  endfunction

  function automatic logic [13:0] obs();
    return {pc_write, i_or_d, mem_req, mem_read, mem_write,
            ir_write, mem_to_reg, pc_source, alu_op,
            alu_src_a, alu_src_b, reg_write};
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [13:0] v_if(input bit r);
    return cv(0,0,1,1,0,r,0,0,2'd0,0,2'd0,0);
  endfunction
  function automatic logic [13:0] v_msd(input bit r);
    return cv(r,1,1,0,1,0,0,0,2'd0,0,2'd1,0);
  endfunction
  function automatic logic [13:0] v_exb(input bit b);
    return cv(!b,0,0,0,0,0,0,!b,2'd1,1,2'd0,0);
  endfunction
  function automatic logic [13:0] v_ec(input bit h);
    return cv(!h,0,0,0,0,0,0,!h,2'd0,0,2'd0,0);
  endfunction

  logic [13:0] V_ID, V_EXR, V_EXI, V_WBR, V_EXLS, V_MLD;
  logic [13:0] V_WBLD, V_MB, V_JAL, V_JALR, V_Z;

  initial begin
    V_ID   = cv(0,0,0,0,0,0,0,0,2'd0,0,2'd1,0);
    V_EXR  = cv(0,0,0,0,0,0,0,0,2'd2,1,2'd0,0);
    V_EXI  = cv(0,0,0,0,0,0,0,0,2'd2,1,2'd2,0);
    V_WBR  = cv(1,0,0,0,0,0,0,0,2'd0,0,2'd1,1);
    V_EXLS = cv(0,0,0,0,0,0,0,0,2'd0,1,2'd2,0);
    V_MLD  = cv(0,1,1,1,0,0,0,0,2'd0,0,2'd0,0);
    V_WBLD = cv(1,0,0,0,0,0,1,0,2'd0,0,2'd1,1);
    V_MB   = cv(1,0,0,0,0,0,0,0,2'd0,0,2'd2,0);
    V_JAL  = cv(1,0,0,0,0,0,0,0,2'd0,0,2'd2,1);
    V_JALR = cv(1,0,0,0,0,0,0,0,2'd0,1,2'd2,1);
    V_Z    = '0;
  end

  // One cycle: drive at negedge, queue the expectation, compare at +1.
  task automatic step(input string t, input logic rdy, bc, hr,
                      input logic [13:0] e, input bit cnt,
                      input bit cc);
    logic [13:0] x;
    mem_ready = rdy;
    alu_bcond = bc;
    halt_req  = hr;
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    chk(t, 64'(obs()), 64'(x));
    if (cc) begin
      chk({t, "_cyc"}, 64'(cycle_cnt), PERF ? 64'(m_cyc) : 64'd0);
      chk({t, "_ret"}, 64'(instret_cnt), PERF ? 64'(m_ret) : 64'd0);
    end
    if (cnt) m_cyc++;
    @(negedge clk);
  endtask

  task automatic fetch(input string t, input logic [6:0] op,
                       input int nw);
    opcode = op;
    for (int i = 0; i < nw; i++)
      step({t, "_ifw"}, 1'b0, rb(), rb(), v_if(0), 1, i == 0);
    step({t, "_if"}, 1'b1, rb(), rb(), v_if(1), 1, nw == 0);
    step({t, "_id"}, rb(), rb(), rb(), V_ID, 1, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_out", 64'(obs()), 64'd0);
    chk("rst_flags", 64'({illegal_inst, halted, mem_timeout}), 64'd0);
    chk("rst_cnt", 64'(cycle_cnt) | 64'(instret_cnt), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_cyc = 0;
    m_ret = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    m_cyc = 0;
    m_ret = 0;
    reset = 1'b1;
    opcode = 7'd0;
    alu_bcond = 1'b0;
    mem_ready = 1'b0;
    halt_req = 1'b0;
    #2;
    do_reset();

    fetch("add", OP_R, 0);
    step("add_ex", rb(), rb(), rb(), V_EXR, 1, 0);
    step("add_wb", rb(), rb(), rb(), V_WBR, 1, 0);
    m_ret++;

    fetch("addi", OP_I, 1);
    step("addi_ex", rb(), rb(), rb(), V_EXI, 1, 0);
    step("addi_wb", rb(), rb(), rb(), V_WBR, 1, 0);
    m_ret++;

    fetch("lw", OP_LOAD, 0);
    step("lw_ex", rb(), rb(), rb(), V_EXLS, 1, 0);
    for (int i = 0; i < 3; i++)
      step("lw_memw", 1'b0, rb(), rb(), V_MLD, 1, 0);
    step("lw_mem", 1'b1, rb(), rb(), V_MLD, 1, 0);
    step("lw_wb", rb(), rb(), rb(), V_WBLD, 1, 0);
    m_ret++;

    fetch("sw", OP_STORE, 0);
    step("sw_ex", rb(), rb(), rb(), V_EXLS, 1, 0);
    step("sw_memw", 1'b0, rb(), rb(), v_msd(0), 1, 0);
    step("sw_mem", 1'b1, rb(), rb(), v_msd(1), 1, 0);
    m_ret++;

    fetch("beqt", OP_BRANCH, 0);
    step("beqt_ex", rb(), 1'b1, rb(), v_exb(1), 1, 0);
    step("beqt_mb", rb(), rb(), rb(), V_MB, 1, 0);
    m_ret++;

    fetch("beqn", OP_BRANCH, 0);
    step("beqn_ex", rb(), 1'b0, rb(), v_exb(0), 1, 0);
    m_ret++;

    fetch("jal", OP_JAL, 0);
    step("jal_ex", rb(), rb(), rb(), V_JAL, 1, 0);
    m_ret++;

    fetch("jalr", OP_JALR, 0);
    step("jalr_ex", rb(), rb(), rb(), V_JALR, 1, 0);
    m_ret++;

    fetch("add15", OP_R, 15);
    step("add15_ex", rb(), rb(), rb(), V_EXR, 1, 0);
    step("add15_wb", rb(), rb(), rb(), V_WBR, 1, 0);
    m_ret++;
    chk("no_tmo", 64'(mem_timeout), 64'd0);

    fetch("ecn", OP_SYSTEM, 0);
    step("ecn_ec", rb(), rb(), 1'b0, v_ec(0), 1, 0);
    m_ret++;

    fetch("ech", OP_SYSTEM, 0);
    step("ech_ec", rb(), rb(), 1'b1, v_ec(1), 1, 0);
    for (int i = 0; i < 4; i++)
      step("halt", rb(), rb(), rb(), V_Z, 0, 1);
    chk("halted", 64'(halted), 64'd1);
    do_reset();

    fetch("ill", 7'b1111111, 0);
    for (int i = 0; i < 4; i++)
      step("trap", rb(), rb(), rb(), V_Z, 0, 1);
    chk("illegal", 64'(illegal_inst), 64'd1);
    chk("ill_tmo", 64'(mem_timeout), 64'd0);
    do_reset();

    opcode = OP_R;
    for (int i = 0; i < 16; i++)
      step("tmo_if", 1'b0, rb(), rb(), v_if(0), 1, i == 0);
    for (int i = 0; i < 3; i++)
      step("tmo_trap", rb(), rb(), rb(), V_Z, 0, 1);
    chk("timeout", 64'(mem_timeout), 64'd1);
    chk("tmo_ill", 64'(illegal_inst), 64'd0);
    do_reset();

    for (int i = 0; i < 3; i++)
      step("abort_if", 1'b0, rb(), rb(), v_if(0), 1, 0);
    mem_ready = 1'b0;
    #1;
    chk("abort_req", 64'(mem_req), 64'd1);
    do_reset();

    fetch("rec", OP_R, 0);
    step("rec_ex", rb(), rb(), rb(), V_EXR, 1, 0);
    step("rec_wb", rb(), rb(), rb(), V_WBR, 1, 0);
    m_ret++;
    step("rec_if", 1'b0, rb(), rb(), v_if(0), 1, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
